// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle control sequencer: state encoding, opcodes,
// ALU operation and immediate-format encodings, and the datapath control word.
package mc_pkg;

  localparam int unsigned MC_STATE_W = 4;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned ALUOP_W    = 4;
  localparam int unsigned IMM_W      = 3;

  typedef enum logic [MC_STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_RSVD     = 4'd11
  } mc_state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } mc_aluop_t;

  typedef enum logic [IMM_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } mc_imm_t;

  // One cycle's worth of datapath selects and enables
  typedef struct packed {
    logic      pc_write;
    logic      adr_src;
    logic      ir_write;
    logic      mem_write;
    logic      reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    mc_aluop_t alu_op;
    logic      retire;
    logic      illegal;
  } mc_ctl_t;

  // Immediate format follows purely from the opcode
  function automatic mc_imm_t imm_src(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_LUI:    return IMM_U;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU operation decode for the EXECUTER/EXECUTEI states; module mc_alu_decoder.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic                i_funct7_b5,
  output mc_aluop_t           o_alu_op
);

  logic w_is_rtype;
  logic w_is_itype;

  assign w_is_rtype = (i_opcode == OP_RTYPE);
  assign w_is_itype = (i_opcode == OP_ITYPE);

  // funct7[5] picks SUB only for register ops; it picks SRA for both forms
  always_comb begin
    o_alu_op = ALU_ADD;
    if (w_is_rtype || w_is_itype) begin
      case (i_funct3)
        3'b000:  o_alu_op = (w_is_rtype && i_funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001:  o_alu_op = ALU_SLL;
        3'b010:  o_alu_op = ALU_SLT;
        3'b011:  o_alu_op = ALU_SLTU;
        3'b100:  o_alu_op = ALU_XOR;
        3'b101:  o_alu_op = i_funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110:  o_alu_op = ALU_OR;
        default: o_alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer driving the shared-memory/shared-ALU datapath.
// Optional MC_MEM_WAIT_EN adds mem_ready to stretch FETCH/MEMREAD/MEMWRITE.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
`ifdef MC_MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          Funct3,
  input  logic [6:0]          Funct7,
  input  logic                zero,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [IMM_W-1:0]    ImmSrc,
  output logic                retire,
  output logic                illegal
);

  logic [STATE_WIDTH-1:0] r_state;
  mc_state_t              w_state;
  mc_state_t              w_state_next;
  mc_ctl_t                w_ctl;
  mc_aluop_t              w_alu_op;
  logic                   w_mem_ready;
  logic                   w_is_load;
  logic                   w_is_store;
  logic                   w_is_rtype;
  logic                   w_is_itype;
  logic                   w_is_lui;
  logic                   w_is_branch;
  logic                   w_is_jal;
  logic                   w_supported;
  logic                   w_unused_funct7;

`ifdef MC_MEM_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  // Only funct7[5] carries meaning for the supported instructions
  assign w_unused_funct7 = ^{Funct7[6], Funct7[4:0]};

  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_rtype  = (opcode == OP_RTYPE);
  assign w_is_itype  = (opcode == OP_ITYPE);
  assign w_is_lui    = (opcode == OP_LUI);
  assign w_is_branch = (opcode == OP_BRANCH) && (Funct3[2:1] == 2'b00);
  assign w_is_jal    = (opcode == OP_JAL);
  assign w_supported = w_is_load | w_is_store | w_is_rtype | w_is_itype |
                       w_is_lui | w_is_branch | w_is_jal;

  assign w_state = mc_state_t'(r_state[MC_STATE_W-1:0]);

  mc_alu_decoder u_alu_decoder (
    .i_opcode    (opcode),
    .i_funct3    (Funct3),
    .i_funct7_b5 (Funct7[5]),
    .o_alu_op    (w_alu_op)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STATE_WIDTH'(S_FETCH);
    end else begin
      r_state <= STATE_WIDTH'(w_state_next);
    end
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      S_FETCH: begin
        if (w_mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_load || w_is_store)     w_state_next = S_MEMADR;
        else if (w_is_rtype)             w_state_next = S_EXECUTER;
        else if (w_is_itype || w_is_lui) w_state_next = S_EXECUTEI;
        else if (w_is_branch)            w_state_next = S_BRANCH;
        else if (w_is_jal)               w_state_next = S_JAL;
        else                             w_state_next = S_FETCH;
      end
      S_MEMADR:   w_state_next = w_is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (w_mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB:    w_state_next = S_FETCH;
      S_MEMWRITE: begin
        if (w_mem_ready) w_state_next = S_FETCH;
      end
      S_EXECUTER: w_state_next = S_ALUWB;
      S_EXECUTEI: w_state_next = S_ALUWB;
      S_ALUWB:    w_state_next = S_FETCH;
      S_BRANCH:   w_state_next = S_FETCH;
      S_JAL:      w_state_next = S_ALUWB;
      default:    w_state_next = S_FETCH;
    endcase
  end

  // Reset masks every enable and pulse so no write can follow its assertion
  always_comb begin
    w_ctl = '0;
    case (w_state)
      S_FETCH: begin
        w_ctl.ir_write   = w_mem_ready;
        w_ctl.pc_write   = w_mem_ready;
        w_ctl.alu_src_a  = 2'b00;
        w_ctl.alu_src_b  = 2'b10;
        w_ctl.alu_op     = ALU_ADD;
        w_ctl.result_src = 2'b10;
      end
      S_DECODE: begin
        w_ctl.alu_src_a = 2'b01;
        w_ctl.alu_src_b = 2'b01;
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.illegal   = ~w_supported;
      end
      S_MEMADR: begin
        w_ctl.alu_src_a = 2'b10;
        w_ctl.alu_src_b = 2'b01;
        w_ctl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        w_ctl.adr_src    = 1'b1;
        w_ctl.result_src = 2'b00;
      end
      S_MEMWB: begin
        w_ctl.result_src = 2'b01;
        w_ctl.reg_write  = 1'b1;
        w_ctl.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        w_ctl.adr_src   = 1'b1;
        w_ctl.mem_write = w_mem_ready;
        w_ctl.retire    = w_mem_ready;
      end
      S_EXECUTER: begin
        w_ctl.alu_src_a = 2'b10;
        w_ctl.alu_src_b = 2'b00;
        w_ctl.alu_op    = w_alu_op;
      end
      S_EXECUTEI: begin
        w_ctl.alu_src_a = w_is_lui ? 2'b11 : 2'b10;
        w_ctl.alu_src_b = 2'b01;
        w_ctl.alu_op    = w_alu_op;
      end
      S_ALUWB: begin
        w_ctl.result_src = 2'b00;
        w_ctl.reg_write  = 1'b1;
        w_ctl.retire     = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a  = 2'b10;
        w_ctl.alu_src_b  = 2'b00;
        w_ctl.alu_op     = ALU_SUB;
        w_ctl.result_src = 2'b00;
        w_ctl.retire     = 1'b1;
        w_ctl.pc_write   = Funct3[0] ? ~zero : zero;
      end
      S_JAL: begin
        w_ctl.alu_src_a  = 2'b01;
        w_ctl.alu_src_b  = 2'b10;
        w_ctl.alu_op     = ALU_ADD;
        w_ctl.result_src = 2'b00;
        w_ctl.pc_write   = 1'b1;
      end
      default: w_ctl = '0;
    endcase
    if (reset) begin
      w_ctl.pc_write  = 1'b0;
      w_ctl.ir_write  = 1'b0;
      w_ctl.mem_write = 1'b0;
      w_ctl.reg_write = 1'b0;
      w_ctl.retire    = 1'b0;
      w_ctl.illegal   = 1'b0;
    end
  end

  assign PCWrite   = w_ctl.pc_write;
  assign AdrSrc    = w_ctl.adr_src;
  assign IRWrite   = w_ctl.ir_write;
  assign MemWrite  = w_ctl.mem_write;
  assign RegWrite  = w_ctl.reg_write;
  assign ResultSrc = w_ctl.result_src;
  assign ALUSrcA   = w_ctl.alu_src_a;
  assign ALUSrcB   = w_ctl.alu_src_b;
  assign ALUOp     = w_ctl.alu_op;
  assign ImmSrc    = imm_src(opcode);
  assign retire    = w_ctl.retire;
  assign illegal   = w_ctl.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle control words against a
// per-instruction-class reference model, directed cases plus random programs.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       zero;
`ifdef MC_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, retire, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUOp;
  logic [2:0] ImmSrc;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       irw;
    logic       memw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [3:0] aluop;
    logic [2:0] imm;
    logic       ret;
    logic       ill;
  } word_t;

  word_t obs;
  word_t exp_q[$];

  assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, retire, illegal};

  mc_control_fsm #(.STATE_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MC_MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .opcode    (opcode),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .zero      (zero),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .retire    (retire),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, LUI = 7'b0110111, BR = 7'b1100011,
                         JAL = 7'b1101111;

  function automatic logic ref_supported(input logic [6:0] op, input logic [2:0] f3);
    if (op == BR) return (f3 == 3'd0) || (f3 == 3'd1);
    return (op == LW) || (op == SW) || (op == RT) || (op == IT) ||
           (op == LUI) || (op == JAL);
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    if (op == SW)  return 3'd1;
    if (op == BR)  return 3'd2;
    if (op == LUI) return 3'd3;
    if (op == JAL) return 3'd4;
    return 3'd0;
  endfunction

  // Arithmetic meaning of funct3: add/sub, sll, slt, sltu, xor, srl/sra, or, and
  function automatic logic [3:0] ref_alu(input logic is_r, input logic [2:0] f3, input logic f7b5);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_r && f7b5) return 4'd1;
    if (f3 == 3'd5 && f7b5) return 4'd7;
    return tbl[f3];
  endfunction

  function automatic word_t fetch_word(input logic [6:0] op, input logic active);
    word_t w;
    w = '0;
    w.imm = ref_imm(op);
    w.irw = active;
    w.pcw = active;
    w.sb  = 2'b10;
    w.res = 2'b10;
    return w;
  endfunction

  // Expected control word for every cycle of one instruction
  task automatic build_expect(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic z);
    word_t base, w, wb;
    exp_q.delete();
    base = '0;
    base.imm = ref_imm(op);
    exp_q.push_back(fetch_word(op, 1'b1));
    w = base; w.sa = 2'b01; w.sb = 2'b01; w.ill = ~ref_supported(op, f3);
    exp_q.push_back(w);
    wb = base; wb.regw = 1'b1; wb.ret = 1'b1;
    if (!ref_supported(op, f3)) return;
    if (op == LW || op == SW) begin
      w = base; w.sa = 2'b10; w.sb = 2'b01; exp_q.push_back(w);
    end
    if (op == LW) begin
      w = base; w.adr = 1'b1; exp_q.push_back(w);
      w = base; w.res = 2'b01; w.regw = 1'b1; w.ret = 1'b1; exp_q.push_back(w);
    end else if (op == SW) begin
      w = base; w.adr = 1'b1; w.memw = 1'b1; w.ret = 1'b1; exp_q.push_back(w);
    end else if (op == RT) begin
      w = base; w.sa = 2'b10; w.aluop = ref_alu(1'b1, f3, f7[5]); exp_q.push_back(w);
      exp_q.push_back(wb);
    end else if (op == IT || op == LUI) begin
      w = base; w.sa = (op == LUI) ? 2'b11 : 2'b10; w.sb = 2'b01;
      w.aluop = (op == LUI) ? 4'd0 : ref_alu(1'b0, f3, f7[5]);
      exp_q.push_back(w);
      exp_q.push_back(wb);
    end else if (op == BR) begin
      w = base; w.sa = 2'b10; w.aluop = 4'd1; w.ret = 1'b1;
      w.pcw = f3[0] ? ~z : z;
      exp_q.push_back(w);
    end else begin
      w = base; w.sa = 2'b01; w.sb = 2'b10; w.pcw = 1'b1; exp_q.push_back(w);
      exp_q.push_back(wb);
    end
  endtask

  // Starts just after a rising edge with the DUT in FETCH; ends likewise
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z);
    opcode = op; Funct3 = f3; Funct7 = f7; zero = z;
    build_expect(op, f3, f7, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = LW; Funct3 = 3'd2; Funct7 = 7'd0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== fetch_word(opcode, 1'b0)) begin
        errors++;
        $display("FAIL reset_hold %0d: got %h expected %h", i, obs, fetch_word(opcode, 1'b0));
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw();
    run_instr("lw", LW, 3'd2, 7'd0, 1'b0);
  endtask

  task automatic test_sw();
    run_instr("sw", SW, 3'd2, 7'd0, 1'b1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken",    BR, 3'd0, 7'd0, 1'b1);
    run_instr("beq_nottaken", BR, 3'd0, 7'd0, 1'b0);
    run_instr("bne_taken",    BR, 3'd1, 7'd0, 1'b0);
    run_instr("bne_nottaken", BR, 3'd1, 7'd0, 1'b1);
  endtask

  task automatic test_alu_ops();
    run_instr("r_sub",  RT, 3'd0, 7'b0100000, 1'b0);
    run_instr("r_add",  RT, 3'd0, 7'b0000000, 1'b0);
    run_instr("i_srai", IT, 3'd5, 7'b0100000, 1'b0);
    run_instr("i_addi", IT, 3'd0, 7'b0100000, 1'b0);
    run_instr("lui",    LUI, 3'd3, 7'b1010101, 1'b0);
    run_instr("jal",    JAL, 3'd0, 7'd0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 7'b1111111, 3'd0, 7'd0, 1'b0);
    run_instr("after_illegal", RT, 3'd7, 7'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    opcode = SW; Funct3 = 3'd2; Funct7 = 7'd0; zero = 1'b0;
    build_expect(SW, 3'd2, 7'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", i + 1, obs, exp_q[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_memwrite: got %b expected 0", MemWrite);
    end
    checks++;
    if (obs !== fetch_word(opcode, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_word: got %h expected %h", obs, fetch_word(opcode, 1'b0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("after_reset_mid", LW, 3'd2, 7'd0, 1'b0);
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    opcode = RT; Funct3 = 3'd0; Funct7 = 7'd0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== fetch_word(opcode, 1'b0)) begin
        errors++;
        $display("FAIL mem_wait_fetch %0d: got %h expected %h", i, obs, fetch_word(opcode, 1'b0));
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    run_instr("after_mem_wait", RT, 3'd0, 7'd0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom);
      f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom);
      case ($urandom_range(0, 7))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = IT;
        4: op = LUI;
        5: begin op = BR; f3 = {2'b00, 1'($urandom)}; end
        6: op = JAL;
        default: begin
          op = 7'h7f;
          for (int t = 0; t < 20; t++) begin
            op = 7'($urandom);
            if (!ref_supported(op, f3)) break;
          end
          if (ref_supported(op, f3)) op = 7'h7f;
        end
      endcase
      run_instr("random", op, f3, f7, 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1;
    opcode = 7'd0; Funct3 = 3'd0; Funct7 = 7'd0; zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    test_reset();
    test_lw();
    test_sw();
    test_branch();
    test_alu_ops();
    test_illegal();
    test_reset_mid();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
